// File: rtl/satd_pkg.sv
// Shared SATD geometry: default pixel/row/block sizes and bus-layout helpers used by the
// packer, SATD core and differences stage.
package satd_pkg;

  localparam int SATD_WIDTH      = 8;
  localparam int SATD_NUM_INPUTS = 8;
  localparam int SATD_ITERATIONS = 8;

  function automatic int row_w(input int width, input int num_inputs);
    return width * num_inputs;
  endfunction

  function automatic int blk_w(input int width, input int num_inputs, input int iterations);
    return width * num_inputs * iterations;
  endfunction

  // Bit offset of row r inside a flat block bus.
  function automatic int row_lsb(input int row, input int rw);
    return row * rw;
  endfunction

endpackage

// File: rtl/satd_blk_bank.sv
// One ORG+CUR block buffer: synchronous clear, one row written per cycle at the given row index.
module satd_blk_bank
  import satd_pkg::*;
#(
  parameter int WIDTH      = SATD_WIDTH,
  parameter int NUM_INPUTS = SATD_NUM_INPUTS,
  parameter int ITERATIONS = SATD_ITERATIONS,
  localparam int ROW_W = row_w(WIDTH, NUM_INPUTS),
  localparam int BLK_W = blk_w(WIDTH, NUM_INPUTS, ITERATIONS),
  localparam int RW    = $clog2(ITERATIONS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [RW-1:0]    row,
  input  logic [ROW_W-1:0] org_row,
  input  logic [ROW_W-1:0] cur_row,
  output logic [BLK_W-1:0] org_blk,
  output logic [BLK_W-1:0] cur_blk
);

  always_ff @(posedge clk) begin
    if (rst) begin
      org_blk <= '0;
      cur_blk <= '0;
    end else if (we) begin
      for (int r = 0; r < ITERATIONS; r++) begin
        if (row == RW'(r)) begin
          org_blk[row_lsb(r, ROW_W) +: ROW_W] <= org_row;
          cur_blk[row_lsb(r, ROW_W) +: ROW_W] <= cur_row;
        end
      end
    end
  end

endmodule

// File: rtl/satd_block_packer.sv
// Ping-pong row-to-block packer feeding the SATD flat ORG/CUR buses; one bank fills while the
// other is held for the consumer.
module satd_block_packer
  import satd_pkg::*;
#(
  parameter int WIDTH      = SATD_WIDTH,
  parameter int NUM_INPUTS = SATD_NUM_INPUTS,
  parameter int ITERATIONS = SATD_ITERATIONS,
  localparam int ROW_W = row_w(WIDTH, NUM_INPUTS),
  localparam int BLK_W = blk_w(WIDTH, NUM_INPUTS, ITERATIONS),
  localparam int RW    = $clog2(ITERATIONS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [ROW_W-1:0] in_org,
  input  logic [ROW_W-1:0] in_cur,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W:0]   ORG,
  output logic [BLK_W:0]   CUR,
  output logic             sync_err
);

  localparam logic [RW-1:0] LAST_ROW = RW'(ITERATIONS - 1);

  // Handshakes: a beat transfers on in_valid && in_ready, a block on out_valid && out_ready.
  // Neither ready depends on the matching valid.
  logic [RW-1:0] row_cnt, row_nxt, wr_row;
  logic          wr_bank, wr_bank_nxt;
  logic          rd_bank, rd_bank_nxt;
  logic [1:0]    full_cnt, full_nxt;
  logic          accept, resync, complete, deliver;
  logic [BLK_W-1:0] org0, cur0, org1, cur1;

  assign in_ready  = (full_cnt < 2'd2);
  assign out_valid = (full_cnt != 2'd0);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;
  assign resync    = accept && in_sof && (row_cnt != '0);
  // A start-of-frame beat always lands in row 0, dropping any partial rows.
  assign wr_row    = in_sof ? '0 : row_cnt;
  assign complete  = accept && (wr_row == LAST_ROW);

  always_comb begin
    row_nxt     = row_cnt;
    wr_bank_nxt = wr_bank;
    rd_bank_nxt = rd_bank;
    full_nxt    = full_cnt;
    if (accept) row_nxt = complete ? '0 : wr_row + RW'(1);
    if (complete) wr_bank_nxt = ~wr_bank;
    if (deliver) rd_bank_nxt = ~rd_bank;
    case ({complete, deliver})
      2'b10:   full_nxt = full_cnt + 2'd1;
      2'b01:   full_nxt = full_cnt - 2'd1;
      default: full_nxt = full_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt  <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      full_cnt <= 2'd0;
      sync_err <= 1'b0;
    end else begin
      row_cnt  <= row_nxt;
      wr_bank  <= wr_bank_nxt;
      rd_bank  <= rd_bank_nxt;
      full_cnt <= full_nxt;
      sync_err <= resync;
    end
  end

  satd_blk_bank #(.WIDTH(WIDTH), .NUM_INPUTS(NUM_INPUTS), .ITERATIONS(ITERATIONS)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .we      (accept && !wr_bank),
    .row     (wr_row),
    .org_row (in_org),
    .cur_row (in_cur),
    .org_blk (org0),
    .cur_blk (cur0)
  );

  satd_blk_bank #(.WIDTH(WIDTH), .NUM_INPUTS(NUM_INPUTS), .ITERATIONS(ITERATIONS)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .we      (accept && wr_bank),
    .row     (wr_row),
    .org_row (in_org),
    .cur_row (in_cur),
    .org_blk (org1),
    .cur_blk (cur1)
  );

  assign ORG = {1'b0, rd_bank ? org1 : org0};
  assign CUR = {1'b0, rd_bank ? cur1 : cur0};

endmodule
